// File: rtl/shared_mem_arbiter_if.sv
// Requester-side bus of the shared SRAM arbiter.
// The master modport is the requester cluster; the slave modport is the arbiter.
interface shared_mem_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_we;
  logic [NUM_REQ-1:0]                 req_last;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]              rsp_rdata;

  modport master (
    output req_valid, req_we, req_last, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_last, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters.
// Grants are combinational (zero-cycle acceptance); a beat without last locks
// the SRAM to its requester until that requester's last beat. Read data comes
// back one cycle after acceptance on the shared rsp_rdata bus.

// Per-requester slice: eligibility for the grant search and the response strobe.
module shared_mem_arbiter_lane #(
  parameter int IW   = 2,
  parameter int LANE = 0
) (
  input  logic          valid,
  input  logic          locked,
  input  logic [IW-1:0] owner,
  input  logic          rsp_vld,
  input  logic [IW-1:0] rsp_idx,
  output logic          elig,
  output logic          rsp_strobe
);
  logic is_owner;

  // While locked only the owner may compete; otherwise any valid requester.
  always_comb begin
    is_owner   = (owner == IW'(LANE));
    elig       = valid & (~locked | is_owner);
    rsp_strobe = rsp_vld & (rsp_idx == IW'(LANE));
  end
endmodule

module shared_mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shared_mem_arbiter_if.slave   bus,
  output logic                  mem_ceb,
  output logic                  mem_web,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_d,
  input  logic [DATA_WIDTH-1:0] mem_q
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ARB, LOCKED} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic                rd_vld_q;
  logic [IW-1:0]       rd_idx_q;

  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  rsp_strobe;
  logic                gnt_any;
  logic [IW-1:0]       gnt_idx;
  logic [IW-1:0]       gnt_next;
  logic                acc_last;
  logic                acc_rd;
  int                  idx;
  logic [IW-1:0]       cand;

  // Per-requester eligibility and response decode.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    shared_mem_arbiter_lane #(.IW(IW), .LANE(i)) u_lane (
      .valid      (bus.req_valid[i]),
      .locked     (state_q == LOCKED),
      .owner      (owner_q),
      .rsp_vld    (rd_vld_q),
      .rsp_idx    (rd_idx_q),
      .elig       (elig[i]),
      .rsp_strobe (rsp_strobe[i])
    );
  end

  // Round-robin search over eligible requesters starting at ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // One-hot grant; ready is only raised on an eligible (hence valid) lane.
  always_comb begin
    bus.req_ready = '0;
    if (gnt_any) bus.req_ready[gnt_idx] = 1'b1;
  end

  // SRAM port driven straight from the granted beat; quiet zeros when idle.
  always_comb begin
    mem_ceb = 1'b1;
    mem_web = 1'b1;
    mem_a   = '0;
    mem_d   = '0;
    if (gnt_any) begin
      mem_ceb = 1'b0;
      mem_web = ~bus.req_we[gnt_idx];
      mem_a   = bus.req_addr[gnt_idx];
      mem_d   = bus.req_wdata[gnt_idx];
    end
  end

  // Next-state: lock on a non-last beat, unlock on the owner's last beat;
  // the pointer moves past whoever finished a burst.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    acc_last = gnt_any & bus.req_last[gnt_idx];
    acc_rd   = gnt_any & ~bus.req_we[gnt_idx];
    gnt_next = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    if (acc_last) ptr_d = gnt_next;
    case (state_q)
      ARB: begin
        if (gnt_any && !acc_last) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
        end
      end
      LOCKED: begin
        if (acc_last) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // Arbitration state; reset drops any lock and restarts the search at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Read-return tracker: one entry, since SRAM latency is a single cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_vld_q <= acc_rd;
      rd_idx_q <= gnt_idx;
    end
  end

  // Shared response bus is zero whenever no read data is due.
  always_comb begin
    bus.rsp_valid = rsp_strobe;
    bus.rsp_rdata = rd_vld_q ? mem_q : '0;
  end

  // Grant stays one-hot and never targets a lane that is not requesting.
  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready));
  a_ready_valid : assert property (@(posedge clk) disable iff (!rst_n)
    ((bus.req_ready & ~bus.req_valid) == '0));
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with an SRAM model and a read scoreboard.
module tb_shared_mem_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_ceb, mem_web;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d, mem_q;

  shared_mem_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  shared_mem_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .mem_ceb (mem_ceb),
    .mem_web (mem_web),
    .mem_a   (mem_a),
    .mem_d   (mem_d),
    .mem_q   (mem_q)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, preloaded on the first edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 32'hA5A5_0000 | i;
      mem[5]     <= 32'hDEAD_BEEF;
      mem_loaded <= 1'b1;
    end else if (!mem_ceb) begin
      if (!mem_web) mem[mem_a] <= mem_d;
      else          mem_q      <= mem[mem_a];
    end
  end

  // Bench-side reference of memory contents.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  typedef struct {
    int           due;
    logic [N-1:0] oh;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] we, input logic [N-1:0] last);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_last  = last;
  endtask

  task automatic beat(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [1:0] ii;
    ii = i[1:0];
    bus.req_addr[ii]  = a;
    bus.req_wdata[ii] = d;
  endtask

  // One cycle: check response, grant and SRAM port mid-cycle, then advance.
  task automatic step(input logic [N-1:0] exp_rdy, input string tag);
    int         g;
    logic [1:0] gi;
    logic [63:0] exp_mem;
    @(negedge clk);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk({tag, "_rspv"}, 64'(bus.rsp_valid), 64'(sb[0].oh));
      chk({tag, "_rdat"}, 64'(bus.rsp_rdata), 64'(sb[0].data));
      void'(sb.pop_front());
    end else begin
      chk({tag, "_rspv"}, 64'(bus.rsp_valid), 64'd0);
      chk({tag, "_rdat"}, 64'(bus.rsp_rdata), 64'd0);
    end
    chk({tag, "_rdy"}, 64'(bus.req_ready), 64'(exp_rdy));
    g = -1;
    for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
    gi = g[1:0];
    if (g < 0) exp_mem = 64'({1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}});
    else       exp_mem = 64'({1'b0, ~bus.req_we[gi], bus.req_addr[gi], bus.req_wdata[gi]});
    chk({tag, "_mem"}, 64'({mem_ceb, mem_web, mem_a, mem_d}), exp_mem);
    if (g >= 0) begin
      if (bus.req_we[gi]) ref_mem[bus.req_addr[gi]] = bus.req_wdata[gi];
      else if (rst_n) sb.push_back('{cyc + 1, exp_rdy, ref_mem[bus.req_addr[gi]]});
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 32'hA5A5_0000 | i;
    ref_mem[5] = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    drive('0, '0, '0);
    for (int i = 0; i < N; i++) beat(i, AW'(i), '0);

    // Reset: idle, then grant computed from ptr=0 and SRAM follows inputs.
    step(4'b0000, "rst_idle");
    drive(4'b1111, 4'b0000, 4'b1111);
    step(4'b0001, "rst_rr0");
    step(4'b0001, "rst_rr1");
    rst_n = 1'b1;
    drive('0, '0, '0);
    step(4'b0000, "idle0");

    // Round-robin rotation with single-beat writes.
    for (int i = 0; i < N; i++) beat(i, AW'(32 + i), 32'h1000 + i);
    drive(4'b1111, 4'b1111, 4'b1111);
    step(4'b0001, "rr0");
    step(4'b0010, "rr1");
    step(4'b0100, "rr2");
    step(4'b1000, "rr3");
    step(4'b0001, "rr_wrap");
    drive('0, '0, '0);
    step(4'b0000, "idle1");

    // Read return on requester 2.
    beat(2, 11'h005, '0);
    drive(4'b0100, 4'b0000, 4'b0100);
    step(4'b0100, "rd2");
    drive('0, '0, '0);
    step(4'b0000, "rd2_rsp");
    step(4'b0000, "rd2_after");

    // Move ptr to 1, then a 3-beat write burst from requester 1 with 0 and 3 waiting.
    beat(0, 11'h030, 32'h0000_0030);
    drive(4'b0001, 4'b0001, 4'b0001);
    step(4'b0001, "ptr_set");
    beat(3, 11'h033, 32'h0000_0033);
    beat(1, 11'h010, 32'hB0B0_0010);
    drive(4'b1011, 4'b1111, 4'b1001);
    step(4'b0010, "bw1");
    beat(1, 11'h011, 32'hB0B0_0011);
    step(4'b0010, "bw2");
    beat(1, 11'h012, 32'hB0B0_0012);
    drive(4'b1011, 4'b1111, 4'b1011);
    step(4'b0010, "bw3");
    drive(4'b1001, 4'b1111, 4'b1001);
    step(4'b1000, "after_b3");
    drive(4'b0001, 4'b1111, 4'b1001);
    step(4'b0001, "after_b0");
    drive('0, '0, '0);
    step(4'b0000, "idle2");

    // Locked read burst from requester 1 with a 2-cycle owner stall.
    beat(1, 11'h010, '0);
    drive(4'b1011, 4'b1001, 4'b1001);
    step(4'b0010, "lk1");
    drive(4'b1001, 4'b1001, 4'b1001);
    step(4'b0000, "stall1");
    step(4'b0000, "stall2");
    beat(1, 11'h011, '0);
    drive(4'b1011, 4'b1001, 4'b1001);
    step(4'b0010, "lk2");
    beat(1, 11'h012, '0);
    drive(4'b1011, 4'b1001, 4'b1011);
    step(4'b0010, "lk3");
    drive('0, '0, '0);
    step(4'b0000, "lk_rsp");
    step(4'b0000, "idle3");

    // Write then read back the top address from requester 0.
    beat(0, 11'h7FF, 32'h1234_5678);
    drive(4'b0001, 4'b0001, 4'b0001);
    step(4'b0001, "wr7ff");
    beat(0, 11'h7FF, '0);
    drive(4'b0001, 4'b0000, 4'b0001);
    step(4'b0001, "rd7ff");
    drive('0, '0, '0);
    step(4'b0000, "rd7ff_rsp");
    step(4'b0000, "idle4");

    // Async reset mid-burst with a read pending.
    beat(2, 11'h005, '0);
    drive(4'b0100, 4'b0000, 4'b0000);
    step(4'b0100, "lkrd");
    chk("pre_rst_rspv", 64'(bus.rsp_valid), 64'(4'b0100));
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) beat(i, AW'(64 + i), 32'h2000 + i);
    drive(4'b1111, 4'b1111, 4'b1111);
    #1;
    chk("rst_rspv", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rdat", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_rdy", 64'(bus.req_ready), 64'(4'b0001));
    chk("rst_ceb", 64'(mem_ceb), 64'd0);
    sb.delete();
    #1;
    rst_n = 1'b1;
    step(4'b0001, "post_rst0");
    step(4'b0010, "post_rst1");
    drive('0, '0, '0);
    step(4'b0000, "idle5");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
